// File: rtl/audio_sample_fifo_if.sv
// Bundle of the audio FIFO's write side, status and codec sample-request signals.
// The FIFO takes the slave modport; the sound engine / codec side takes the master modport.
interface audio_sample_fifo_if #(
  parameter int DEPTH = 64
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        almost_empty;
  logic [LW-1:0] level;
  logic        overflow;
  logic        clear_status;
  logic        mute;
  logic [1:0]  sample_req;
  logic [15:0] audio_output;
  logic [15:0] underrun_count;

  modport master (
    output wr_en, wr_data, clear_status, mute, sample_req,
    input  full, almost_empty, level, overflow, audio_output, underrun_count
  );

  modport slave (
    input  wr_en, wr_data, clear_status, mute, sample_req,
    output full, almost_empty, level, overflow, audio_output, underrun_count
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// Stereo frame FIFO feeding the SSM2603 serializer: one frame is popped per left
// request, its right half is held for the following right request.
module audio_sample_fifo #(
  parameter int DEPTH     = 64,
  parameter int AE_THRESH = 16
) (
  input logic             clk,
  input logic             reset,
  audio_sample_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [LW-1:0] level_q;
  logic [15:0]   right_hold;
  logic [15:0]   audio_q;
  logic [15:0]   underrun_q;
  logic          overflow_q;

  logic          is_empty;
  logic          is_full;
  logic          pop;
  logic          push;
  logic          underrun_evt;
  logic          overflow_evt;
  logic [31:0]   rd_frame;

  // Decisions use only registered level, so wr_en never reaches full/level combinationally.
  always_comb begin
    is_empty     = (level_q == '0);
    is_full      = (level_q == LW'(DEPTH));
    pop          = bus.sample_req[1] && !is_empty;
    push         = bus.wr_en && (!is_full || pop);
    underrun_evt = bus.sample_req[1] && is_empty;
    overflow_evt = bus.wr_en && is_full && !pop;
    rd_frame     = mem[rd_ptr];
  end

  // NOTE: the sample memory has no reset; pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // A left request always reloads both the output and the right-hold, even on underrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      audio_q    <= '0;
      right_hold <= '0;
    end else if (bus.sample_req[1]) begin
      if (pop) begin
        audio_q    <= bus.mute ? 16'h0000 : rd_frame[31:16];
        right_hold <= rd_frame[15:0];
      end else begin
        audio_q    <= '0;
        right_hold <= '0;
      end
    end else if (bus.sample_req[0]) begin
      audio_q <= bus.mute ? 16'h0000 : right_hold;
    end
  end

  // A new event beats a coincident clear_status.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      underrun_q <= '0;
    end else begin
      if (overflow_evt)          overflow_q <= 1'b1;
      else if (bus.clear_status) overflow_q <= 1'b0;

      if (underrun_evt) begin
        if (bus.clear_status)          underrun_q <= 16'd1;
        else if (underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
      end else if (bus.clear_status) begin
        underrun_q <= '0;
      end
    end
  end

  assign bus.full           = is_full;
  assign bus.almost_empty   = (level_q <= LW'(AE_THRESH));
  assign bus.level          = level_q;
  assign bus.overflow       = overflow_q;
  assign bus.audio_output   = audio_q;
  assign bus.underrun_count = underrun_q;
endmodule

// File: tb/tb_audio_sample_fifo.sv
// Randomized scoreboard bench for audio_sample_fifo against a queue-based frame model.
module tb_audio_sample_fifo;
  localparam int DEPTH     = 64;
  localparam int AE_THRESH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  audio_sample_fifo_if #(.DEPTH(DEPTH)) bus ();

  audio_sample_fifo #(.DEPTH(DEPTH), .AE_THRESH(AE_THRESH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: stored frames, held right sample, status registers.
  logic [31:0] m_q[$];
  logic [15:0] m_hold;
  logic        m_ovf;
  logic [15:0] m_und;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_hold = '0;
    m_ovf  = 1'b0;
    m_und  = '0;
  endfunction

  function automatic void model_step(input logic we, input logic [31:0] wd,
                                     input logic [1:0] req, input logic clr, input logic mu);
    logic        popped;
    logic        was_full;
    logic        ovf_evt;
    logic        und_evt;
    logic [31:0] frame;
    popped   = 1'b0;
    ovf_evt  = 1'b0;
    und_evt  = 1'b0;
    was_full = (m_q.size() == DEPTH);
    if (req[1]) begin
      if (m_q.size() > 0) begin
        frame  = m_q.pop_front();
        popped = 1'b1;
        exp_q.push_back(mu ? 16'h0000 : frame[31:16]);
        m_hold = frame[15:0];
      end else begin
        exp_q.push_back(16'h0000);
        m_hold  = '0;
        und_evt = 1'b1;
      end
    end else if (req[0]) begin
      exp_q.push_back(mu ? 16'h0000 : m_hold);
    end
    if (we) begin
      if (!was_full || popped) m_q.push_back(wd);
      else ovf_evt = 1'b1;
    end
    if (ovf_evt) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (und_evt) m_und = clr ? 16'd1 : ((m_und == 16'hFFFF) ? 16'hFFFF : m_und + 16'd1);
    else if (clr) m_und = '0;
  endfunction

  task automatic check_status();
    check("level", 32'(bus.level), 32'(m_q.size()));
    check("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
    check("almost_empty", 32'(bus.almost_empty), 32'(m_q.size() <= AE_THRESH));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("underrun_count", 32'(bus.underrun_count), 32'(m_und));
  endtask

  // Called at posedge+1; drives one cycle of stimulus and returns at the next posedge+1.
  task automatic step(input logic we, input logic [31:0] wd, input logic [1:0] req,
                      input logic clr, input logic mu, input bit chk = 1'b1);
    bus.wr_en        = we;
    bus.wr_data      = wd;
    bus.sample_req   = req;
    bus.clear_status = clr;
    bus.mute         = mu;
    model_step(we, wd, req, clr, mu);
    @(posedge clk);
    #1;
    bus.wr_en        = 1'b0;
    bus.sample_req   = 2'b00;
    bus.clear_status = 1'b0;
    if (chk) check_status();
  endtask

  task automatic do_reset();
    step(1'b0, '0, 2'b00, 1'b0, bus.mute, 1'b0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_status();
    check("audio_output_after_reset", 32'(bus.audio_output), 32'h0);
  endtask

  // Monitor: any request seen at an edge produces an output compared half a cycle later.
  initial begin
    logic [1:0]  seen;
    logic [15:0] want;
    forever begin
      @(posedge clk);
      seen = bus.sample_req;
      if (!reset && seen != 2'b00) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 32'(bus.audio_output), 32'hDEAD);
        end else begin
          want = exp_q.pop_front();
          check("audio_output", 32'(bus.audio_output), 32'(want));
        end
      end
    end
  end

  initial begin
    logic [15:0] v;
    logic        mu;
    int          r;
    reset            = 1'b1;
    bus.wr_en        = 1'b0;
    bus.wr_data      = '0;
    bus.sample_req   = 2'b00;
    bus.clear_status = 1'b0;
    bus.mute         = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_status();
    check("audio_output_reset", 32'(bus.audio_output), 32'h0);

    // Underrun on an empty FIFO.
    step(1'b0, '0, 2'b10, 1'b0, 1'b0);

    // Single frame: left then right.
    step(1'b1, 32'h1234_ABCD, 2'b00, 1'b0, 1'b0);
    step(1'b0, '0, 2'b10, 1'b0, 1'b0);
    step(1'b0, '0, 2'b01, 1'b0, 1'b0);

    // Overfill by one, drain all, wrap the read pointer, clear the overflow.
    for (int i = 0; i <= DEPTH; i++) begin
      v = 16'(i);
      step(1'b1, {v, ~v}, 2'b00, 1'b0, 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 2'b10, 1'b0, 1'b0);
    step(1'b0, '0, 2'b00, 1'b1, 1'b0);

    // Full FIFO with simultaneous write and pop.
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 2'b00, 1'b0, 1'b0);
    step(1'b1, 32'hCAFE_F00D, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 2'b10, 1'b0, 1'b0);
      step(1'b0, '0, 2'b01, 1'b0, 1'b0);
    end

    // Mute drains silently; unmute restores data.
    step(1'b1, 32'h7FFF_8000, 2'b00, 1'b0, 1'b0);
    step(1'b1, 32'h0001_0002, 2'b00, 1'b0, 1'b1);
    step(1'b0, '0, 2'b10, 1'b0, 1'b1);
    step(1'b0, '0, 2'b01, 1'b0, 1'b1);
    step(1'b0, '0, 2'b10, 1'b0, 1'b0);
    step(1'b0, '0, 2'b01, 1'b0, 1'b0);

    // Underrun counter saturation, then clear coinciding with a new underrun.
    while (m_q.size() > 0) step(1'b0, '0, 2'b10, 1'b0, 1'b0);
    step(1'b0, '0, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 16'hFFFE; i++) step(1'b0, '0, 2'b10, 1'b0, 1'b0, 1'b0);
    check_status();
    step(1'b0, '0, 2'b10, 1'b0, 1'b0);
    step(1'b0, '0, 2'b10, 1'b0, 1'b0);
    step(1'b0, '0, 2'b10, 1'b1, 1'b0);
    step(1'b1, 32'h5555_AAAA, 2'b11, 1'b0, 1'b0);

    // Randomized traffic with a mid-run reset.
    mu = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 29) == 0) mu = ~mu;
      step(($urandom_range(0, 9) < ((i % 200) < 100 ? 7 : 3)), $urandom,
           (r < 6) ? 2'b00 : (r < 8) ? 2'b10 : (r == 8) ? 2'b01 : 2'b11,
           ($urandom_range(0, 19) == 0), mu);
    end

    step(1'b0, '0, 2'b00, 1'b0, 1'b0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/audio_sample_fifo.md
Name: audio_sample_fifo

Overview:
- Stereo sample buffer directly upstream of the SSM2603 codec serializer.
- Software or the sound engine pushes packed 32-bit left/right frames.
- The block answers the serializer's per-channel sample requests with 16-bit samples on audio_output.
- Handles underrun (silence plus counter), overflow (sticky flag), mute, and an almost-empty level indication for refill interrupts.

Parameters:
- DEPTH, 64, number of stereo frames stored; power of 2, minimum 4.
- AE_THRESH, 16, almost_empty asserts when level <= AE_THRESH.
- LW, $clog2(DEPTH)+1, width of level output (derived; not overridden).

Ports:
- clk  in  1  system clock (codec master clock domain).
- reset  in  1  synchronous, active-high.
- wr_en  in  1  push one frame this cycle.
- wr_data  in  32  frame: [31:16] left, [15:0] right, two's complement.
- full  out  1  level == DEPTH.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  LW  frames currently stored.
- overflow  out  1  sticky: a write was dropped.
- clear_status  in  1  clears overflow and underrun_count.
- mute  in  1  force silent samples; FIFO still drains.
- sample_req  in  2  [1]: left sample needed; [0]: right sample needed; single-cycle pulses from codec.
- audio_output  out  16  sample presented to codec.
- underrun_count  out  16  saturating count of frames requested while empty.

Behaviour:
- Reset values: audio_output 0, level 0, full 0, almost_empty 1, overflow 0, underrun_count 0, internal right-hold register 0, read/write pointers 0.
- Storage: DEPTH x 32 memory, binary read/write pointers wrapping modulo DEPTH; level tracked by a separate counter.
- Reset mid-operation discards all stored frames.
- Pop occurs only on sample_req[1]. Latency: audio_output updated on the clock edge after the sample_req pulse, then held until the next update.
- sample_req[1], FIFO non-empty:
  - pop one frame;
  - audio_output <= left, or 0 if mute;
  - right-hold <= right.
- sample_req[1], FIFO empty:
  - no pop; audio_output <= 0; right-hold <= 0;
  - underrun_count increments, saturating at 16'hFFFF.
- sample_req[0]: audio_output <= right-hold, or 0 if mute. No pop.
- sample_req == 2'b11: treated as sample_req[1] only; the [0] bit is ignored.
- Write with level < DEPTH: stored; level +1.
- Write when full and no pop this cycle: dropped; overflow <= 1.
- Write when full with a pop the same cycle: accepted; level unchanged.
- Write and pop the same cycle, non-empty: level unchanged; both pointers advance.
- Write into an empty FIFO in the same cycle as sample_req[1]: counts as an underrun (no bypass). The written frame is stored; level becomes 1.
- clear_status: overflow <= 0 and underrun_count <= 0 on the next edge.
- Priority if clear_status coincides with a new overflow or underrun event: the event wins (overflow 1, underrun_count 1).
- full, almost_empty and level are registered-derived: they reflect state after the current edge, with no combinational path from wr_en.
- mute changes take effect at the next sample_req; audio_output is not altered mid-hold.

Test Plan:
- Reset, then sample_req[1] pulse -> audio_output 0, underrun_count 1, level 0, almost_empty 1.
- Write 32'h1234_ABCD, then sample_req[1] -> audio_output 16'h1234 one cycle later. Then sample_req[0] -> 16'hABCD. Level returns 0; no underrun counted.
- Write DEPTH+1 frames (values 0..64) with no requests -> full 1 after the 64th write, 65th dropped, overflow 1. Then pull 64 frames -> lefts 0..63 in order, read pointer wraps cleanly. Then clear_status -> overflow 0.
- With FIFO full, assert wr_en and sample_req[1] in the same cycle -> write accepted, level stays 64, overflow stays 0.
- mute=1 with frame 32'h7FFF_8000 queued: sample_req[1] then [0] -> both outputs 0 and level decrements. Then mute=0 with next frame 32'h0001_0002 -> outputs 1 then 2.
- Preload underrun_count to 16'hFFFE via repeated empty requests; two more empty requests -> count holds 16'hFFFF. Assert clear_status alongside an empty sample_req[1] -> count 1.
